buck_duty_sequencer: RTL and testbench

Soft-start and setpoint sequencer for the buck converter's PWM stage. It accepts a target duty word through a valid/ready handshake. It slews the duty command toward that target one LSB per programmable tick and gates the PWM enable. It forces an immediate shutdown on a fault input. It sits between the control loop or host and the PWM generator's `duty_cycle` input.

---
 rtl/buck_duty_sequencer.sv | 146 ++++++++++++++
 tb/tb_buck_duty_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/buck_duty_sequencer.sv
// Soft-start / setpoint sequencer feeding the PWM generator's duty input.
// Accepts a clamped target over valid/ready, slews the duty command one LSB
// every RAMP_DIV clocks, gates the PWM enable and latches faults until the
// requester drops enable.
module buck_duty_sequencer #(
  parameter int PWM_RESOLUTION = 10,
  parameter int RAMP_DIV       = 1000,
  parameter int DUTY_MAX       = 900
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_i,
  input  logic                      fault_i,
  input  logic [PWM_RESOLUTION-1:0] target_duty_i,
  input  logic                      target_valid_i,
  output logic                      target_ready_o,
  output logic [PWM_RESOLUTION-1:0] duty_out_o,
  output logic                      pwm_en_o,
  output logic [1:0]                state_o,
  output logic                      ramp_done_o
);

  localparam int PW = $clog2(RAMP_DIV);
  localparam logic [PW-1:0]             PRESC_TC  = PW'(RAMP_DIV - 1);
  localparam logic [PW-1:0]             PRESC_ONE = PW'(1);
  localparam logic [PWM_RESOLUTION-1:0] DUTY_CAP  = PWM_RESOLUTION'(DUTY_MAX);
  localparam logic [PWM_RESOLUTION-1:0] DUTY_ONE  = PWM_RESOLUTION'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RAMP  = 2'b01,
    RUN   = 2'b10,
    FAULT = 2'b11
  } state_e;

  state_e                    state_q, state_d;
  logic [PWM_RESOLUTION-1:0] duty_q, duty_d;
  logic [PWM_RESOLUTION-1:0] target_q, target_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic                      pwm_en_q, pwm_en_d;
  logic                      ramp_done_q, ramp_done_d;

  logic                      xfer;
  logic [PWM_RESOLUTION-1:0] target_clamped;

  // Ready is the only combinational output; a fault blocks any capture.
  assign target_ready_o = (state_q != FAULT);
  assign xfer           = target_valid_i & target_ready_o & ~fault_i;
  assign target_clamped = (target_duty_i > DUTY_CAP) ? DUTY_CAP : target_duty_i;

  // State register and all registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      target_q    <= '0;
      presc_q     <= '0;
      pwm_en_q    <= 1'b0;
      ramp_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      presc_q     <= presc_d;
      pwm_en_q    <= pwm_en_d;
      ramp_done_q <= ramp_done_d;
    end
  end

  // Next-state, ramp stepping and target capture; fault outranks everything.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    presc_d  = presc_q;

    if (fault_i) begin
      state_d = FAULT;
      duty_d  = '0;
      presc_d = '0;
    end else begin
      // A capture updates the target in every non-fault state.
      if (xfer) begin
        target_d = target_clamped;
      end
      case (state_q)
        IDLE: begin
          duty_d  = '0;
          presc_d = '0;
          if (enable_i) begin
            state_d = RAMP;
          end
        end
        RAMP: begin
          if (!enable_i) begin
            state_d = IDLE;
            duty_d  = '0;
            presc_d = '0;
          end else if (xfer) begin
            // Retarget restarts the tick cadence; equality is rechecked next cycle.
            presc_d = '0;
          end else if (duty_q == target_q) begin
            state_d = RUN;
            presc_d = '0;
          end else if (presc_q == PRESC_TC) begin
            presc_d = '0;
            duty_d  = (duty_q < target_q) ? duty_q + DUTY_ONE : duty_q - DUTY_ONE;
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        RUN: begin
          if (!enable_i) begin
            state_d = IDLE;
            duty_d  = '0;
            presc_d = '0;
          end else if (xfer && (target_clamped != duty_q)) begin
            state_d = RAMP;
            presc_d = '0;
          end
        end
        FAULT: begin
          duty_d  = '0;
          presc_d = '0;
          if (!enable_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
          presc_d = '0;
        end
      endcase
    end

    pwm_en_d    = (state_d == RAMP) || (state_d == RUN);
    ramp_done_d = (state_d == RUN);
  end

  assign duty_out_o  = duty_q;
  assign pwm_en_o    = pwm_en_q;
  assign state_o     = state_q;
  assign ramp_done_o = ramp_done_q;

endmodule

// File: tb/tb_buck_duty_sequencer.sv
// Directed bench for buck_duty_sequencer with RAMP_DIV=4, DUTY_MAX=900.
module tb_buck_duty_sequencer;

  localparam int W = 10;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         fault;
  logic [W-1:0] target_duty;
  logic         target_valid;
  logic         target_ready;
  logic [W-1:0] duty_out;
  logic         pwm_en;
  logic [1:0]   state;
  logic         ramp_done;

  int vectors;
  int miscompares;

  buck_duty_sequencer #(
    .PWM_RESOLUTION(W),
    .RAMP_DIV(4),
    .DUTY_MAX(900)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_i(enable),
    .fault_i(fault),
    .target_duty_i(target_duty),
    .target_valid_i(target_valid),
    .target_ready_o(target_ready),
    .duty_out_o(duty_out),
    .pwm_en_o(pwm_en),
    .state_o(state),
    .ramp_done_o(ramp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Advance n clock edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] st, input logic [31:0] dty,
                         input logic [31:0] en, input logic [31:0] rd);
    chk({tag, ".state"}, state, st);
    chk({tag, ".duty"}, duty_out, dty);
    chk({tag, ".pwm_en"}, pwm_en, en);
    chk({tag, ".ramp_done"}, ramp_done, rd);
  endtask

  task automatic send_target(input logic [W-1:0] t);
    target_duty  = t;
    target_valid = 1'b1;
    step(1);
    target_valid = 1'b0;
  endtask

  // Wait for RUN with a cycle budget; a timeout shows up as a state miscompare.
  task automatic wait_run(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state == 2'b10) break;
      step(1);
    end
    chk(tag, state, 2);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    fault        = 1'b0;
    target_duty  = '0;
    target_valid = 1'b0;

    // Reset values
    step(1);
    chk_all("reset", 0, 0, 0, 0);
    chk("reset.ready", target_ready, 1);
    rst_n = 1'b1;

    // Soft-start to 5
    send_target(10'd5);
    chk("idle_after_xfer.state", state, 0);
    enable = 1'b1;
    step(1);
    chk_all("ss_e0", 1, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      step(4);
      chk($sformatf("ss_step%0d.duty", k), duty_out, k);
    end
    chk("ss_e20.state", state, 1);
    step(1);
    chk_all("ss_e21", 2, 5, 1, 1);

    // Clamp: 1000 -> 900
    send_target(10'd1000);
    chk("clamp_xfer.state", state, 1);
    step(4);
    chk("clamp_first.duty", duty_out, 6);
    wait_run("clamp_run.state", 4000);
    chk("clamp_run.duty", duty_out, 900);

    // Downward retarget 898
    send_target(10'd898);
    chk("down_xfer.state", state, 1);
    step(4);
    chk("down_1.duty", duty_out, 899);
    step(4);
    chk("down_2.duty", duty_out, 898);
    step(1);
    chk_all("down_run", 2, 898, 1, 1);

    // Disable from RUN, then load target 6 in IDLE
    enable = 1'b0;
    step(1);
    chk_all("dis_run", 0, 0, 0, 0);
    send_target(10'd6);
    enable = 1'b1;
    step(1);
    chk("f_ramp.state", state, 1);
    step(12);
    chk("f_pre.duty", duty_out, 3);

    // Fault coinciding with a transfer of 7
    fault        = 1'b1;
    target_duty  = 10'd7;
    target_valid = 1'b1;
    step(1);
    target_valid = 1'b0;
    chk_all("fault", 3, 0, 0, 0);
    chk("fault.ready", target_ready, 0);
    fault = 1'b0;
    step(2);
    chk("fault_held.state", state, 3);
    enable = 1'b0;
    step(1);
    chk("fault_exit.state", state, 0);
    chk("fault_exit.ready", target_ready, 1);
    enable = 1'b1;
    step(1);
    chk("recover.state", state, 1);
    step(24);
    chk("recover.duty", duty_out, 6);
    step(1);
    chk_all("recover_run", 2, 6, 1, 1);

    // Disable mid-ramp at duty 2, then restart from 0
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(9);
    chk("mid.duty", duty_out, 2);
    enable = 1'b0;
    step(1);
    chk_all("mid_dis", 0, 0, 0, 0);
    enable = 1'b1;
    step(1);
    chk_all("restart", 1, 0, 1, 0);
    step(4);
    chk("restart.duty", duty_out, 1);

    // Retarget to 5, reach RUN, then async reset between edges
    send_target(10'd5);
    wait_run("ar_run.state", 100);
    chk("ar_run.duty", duty_out, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    chk("async_rst.ready", target_ready, 1);
    #1;
    rst_n = 1'b1;

    // Target register reset to 0: one RAMP cycle then RUN at 0
    step(1);
    chk_all("zero_ramp", 1, 0, 1, 0);
    step(1);
    chk_all("zero_run", 2, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
